main_fsm: RTL and testbench

- Multicycle controller state machine that produces the per-cycle control strobes consumed by the condition logic: NextPC, RegW, MemW, Branch. It also produces the datapath mux selects and IRWrite.
- Sits in the controller beside the instruction decoder. It takes Op/Funct from the instruction register and advances one state per cycle.
- Memory states stall on an optional memory-ready handshake.

---
 rtl/main_fsm_pkg.sv | 56 +++++
 rtl/main_fsm_if.sv | 33 +++
 rtl/main_fsm_outdec.sv | 72 +++++++
 rtl/main_fsm.sv | 90 +++++++++
 tb/tb_main_fsm.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/main_fsm_pkg.sv
// Shared types and encodings for the multicycle controller state machine:
// state enum, datapath select codes, instruction classes and the control vector.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_e;

    localparam logic [1:0] SRCA_REG      = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT   = 2'b10;

    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP         = 2'b00;
    localparam logic [1:0] OP_MEM        = 2'b01;
    localparam logic [1:0] OP_BR         = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    // All strobes low and all selects at code 00.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and memory ready in,
// per-cycle control strobes and mux selects out.
interface main_fsm_if;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemRdy;

    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       Illegal;

    modport master (
        input  Op, Funct, MemRdy,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, NextPC, RegW, MemW, Branch, Illegal
    );

    modport slave (
        output Op, Funct, MemRdy,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, NextPC, RegW, MemW, Branch, Illegal
    );

endinterface

// File: rtl/main_fsm_outdec.sv
// Moore output decode: maps the registered state onto the control vector.
// Unused state encodings decode to an all-zero vector.
module main_fsm_outdec
    import main_fsm_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    // State-to-control lookup; anything not named for a state stays 0.
    always_comb begin
        ctrl_o = ctrl_idle();
        case (state_i)
            S_FETCH: begin
                ctrl_o.ir_write   = 1'b1;
                ctrl_o.next_pc    = 1'b1;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALURESULT;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a  = SRCA_REG;
                ctrl_o.alu_src_b  = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl_o.result_src = RES_DATA;
                ctrl_o.reg_w      = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.mem_w      = 1'b1;
            end
            S_EXECUTER: begin
                ctrl_o.alu_src_a  = SRCA_REG;
                ctrl_o.alu_src_b  = SRCB_REG;
                ctrl_o.alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                ctrl_o.alu_src_a  = SRCA_REG;
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = SRCA_ALUOUT;
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.result_src = RES_ALURESULT;
                ctrl_o.branch     = 1'b1;
            end
            S_UNKNOWN: begin
                ctrl_o.illegal    = 1'b1;
            end
            default: begin
                ctrl_o = ctrl_idle();
            end
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle controller: state register plus next-state logic; outputs are a
// pure decode of the state register, so every strobe is glitch-free per cycle.
module main_fsm
    import main_fsm_pkg::*;
#(
    parameter int USE_MEMRDY = 0
) (
    input  logic       clk,
    input  logic       reset,
    main_fsm_if.master bus
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_s;
    logic   mem_rdy_s;
    logic   unused_funct_s;

    // Without the handshake the memory is assumed to complete in one cycle.
    assign mem_rdy_s      = (USE_MEMRDY != 0) ? bus.MemRdy : 1'b1;
    assign unused_funct_s = ^bus.Funct[4:1];

    // State register; low reset forces FETCH immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state rules; Op/Funct are consulted only in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                if (mem_rdy_s) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                case (bus.Op)
                    OP_MEM: state_d = S_MEMADR;
                    OP_DP: begin
                        if (bus.Funct[5]) state_d = S_EXECUTEI;
                        else              state_d = S_EXECUTER;
                    end
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR: begin
                if (bus.Funct[0]) state_d = S_MEMRD;
                else              state_d = S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_rdy_s) state_d = S_MEMWB;
                else           state_d = S_MEMRD;
            end
            S_MEMWR: begin
                if (mem_rdy_s) state_d = S_FETCH;
                else           state_d = S_MEMWR;
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_MEMWB:    state_d = S_FETCH;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_UNKNOWN:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    main_fsm_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (ctrl_s)
    );

    assign bus.IRWrite   = ctrl_s.ir_write;
    assign bus.AdrSrc    = ctrl_s.adr_src;
    assign bus.ALUSrcA   = ctrl_s.alu_src_a;
    assign bus.ALUSrcB   = ctrl_s.alu_src_b;
    assign bus.ResultSrc = ctrl_s.result_src;
    assign bus.ALUOp     = ctrl_s.alu_op;
    assign bus.NextPC    = ctrl_s.next_pc;
    assign bus.RegW      = ctrl_s.reg_w;
    assign bus.MemW      = ctrl_s.mem_w;
    assign bus.Branch    = ctrl_s.branch;
    assign bus.Illegal   = ctrl_s.illegal;

endmodule

// File: tb/tb_main_fsm.sv
// Randomized bench for main_fsm: one DUT without and one with the MemRdy
// handshake, both checked every cycle against an instruction-route model.
module tb_main_fsm;

    logic clk;
    logic reset;

    main_fsm_if bus0 ();
    main_fsm_if bus1 ();

    main_fsm #(.USE_MEMRDY(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    main_fsm #(.USE_MEMRDY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step labels of the model (independent of any RTL encoding).
    localparam int L_FETCH = 100, L_DECODE = 101, L_MEMADR = 102, L_MEMRD = 103,
                   L_MEMWB = 104, L_MEMWR = 105, L_EXR = 106, L_EXI = 107,
                   L_ALUWB = 108, L_BR = 109, L_UNK = 110;

    int n_vec = 0;
    int n_err = 0;

    int cur[2];
    int plan[2][4];
    int plen[2];
    int ilen[2];
    int exp_len[2];

    logic [14:0] obs0, obs1;
    assign obs0 = {bus0.IRWrite, bus0.AdrSrc, bus0.ALUSrcA, bus0.ALUSrcB, bus0.ResultSrc,
                   bus0.ALUOp, bus0.NextPC, bus0.RegW, bus0.MemW, bus0.Branch, bus0.Illegal};
    assign obs1 = {bus1.IRWrite, bus1.AdrSrc, bus1.ALUSrcA, bus1.ALUSrcB, bus1.ResultSrc,
                   bus1.ALUOp, bus1.NextPC, bus1.RegW, bus1.MemW, bus1.Branch, bus1.Illegal};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch,Illegal}
    function automatic logic [14:0] exp_ctl(input int lbl);
        case (lbl)
            L_FETCH:  return {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            L_DECODE: return {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            L_MEMADR: return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            L_MEMRD:  return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            L_MEMWB:  return {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            L_MEMWR:  return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            L_EXR:    return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            L_EXI:    return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            L_ALUWB:  return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            L_BR:     return {1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            L_UNK:    return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            default:  return 15'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            cur[i] = L_FETCH; plen[i] = 0; ilen[i] = 1; exp_len[i] = 0;
        end
    endtask

    task automatic push(input int i, input int lbl);
        plan[i][plen[i]] = lbl;
        plen[i]++;
    endtask

    task automatic pop(input int i);
        cur[i] = plan[i][0];
        for (int k = 0; k < 3; k++) plan[i][k] = plan[i][k+1];
        plen[i]--;
    endtask

    // One clock edge of the instruction-route model for DUT i.
    task automatic model_step(input int i, input logic [1:0] op, input logic [5:0] fn, input logic rdy);
        bit stall;
        stall = (i == 1) && !rdy &&
                (cur[i] == L_FETCH || cur[i] == L_MEMRD || cur[i] == L_MEMWR);
        if (!stall) begin
            if (cur[i] == L_FETCH) begin
                cur[i] = L_DECODE;
            end else if (cur[i] == L_DECODE) begin
                plen[i] = 0;
                case (op)
                    2'b00: begin push(i, fn[5] ? L_EXI : L_EXR); push(i, L_ALUWB); exp_len[i] = 4; end
                    2'b01: begin push(i, L_MEMADR); exp_len[i] = 0; end
                    2'b10: begin push(i, L_BR); exp_len[i] = 3; end
                    default: begin push(i, L_UNK); exp_len[i] = 3; end
                endcase
                pop(i);
            end else if (cur[i] == L_MEMADR) begin
                if (fn[0]) begin push(i, L_MEMRD); push(i, L_MEMWB); exp_len[i] = 5; end
                else       begin push(i, L_MEMWR); exp_len[i] = 4; end
                pop(i);
            end else if (plen[i] > 0) begin
                pop(i);
            end else begin
                cur[i] = L_FETCH;
            end
            if (cur[i] == L_FETCH) begin
                chk($sformatf("instr_len%0d", i), ilen[i], exp_len[i]);
                ilen[i] = 1;
            end else begin
                ilen[i]++;
            end
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic rdy);
        bus0.Op = op; bus0.Funct = fn; bus0.MemRdy = rdy;
        bus1.Op = op; bus1.Funct = fn; bus1.MemRdy = rdy;
    endtask

    task automatic cycle(input logic [1:0] op, input logic [5:0] fn, input logic rdy);
        drive(op, fn, rdy);
        @(posedge clk);
        #1;
        model_step(0, op, fn, rdy);
        model_step(1, op, fn, rdy);
        chk($sformatf("dut0_ctl_s%0d", cur[0]), {17'd0, obs0}, {17'd0, exp_ctl(cur[0])});
        chk($sformatf("dut1_ctl_s%0d", cur[1]), {17'd0, obs1}, {17'd0, exp_ctl(cur[1])});
    endtask

    // Asynchronous reset pulse placed mid-cycle, outputs checked while low.
    task automatic reset_pulse(input string tag);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk({tag, "_dut0"}, {17'd0, obs0}, {17'd0, exp_ctl(L_FETCH)});
        chk({tag, "_dut1"}, {17'd0, obs1}, {17'd0, exp_ctl(L_FETCH)});
        #2 reset = 1'b1;
    endtask

    int memw_cnt;

    initial begin
        reset = 1'b0;
        drive(2'b00, 6'b000000, 1'b1);
        model_reset();
        #2;
        chk("reset_dut0", {17'd0, obs0}, {17'd0, exp_ctl(L_FETCH)});
        chk("reset_dut1", {17'd0, obs1}, {17'd0, exp_ctl(L_FETCH)});
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold_dut0", {17'd0, obs0}, {17'd0, exp_ctl(L_FETCH)});
        reset = 1'b1;

        repeat (5) cycle(2'b01, 6'b000001, 1'b1);   // LDR
        repeat (4) cycle(2'b01, 6'b000000, 1'b1);   // STR
        repeat (4) cycle(2'b00, 6'b101000, 1'b1);   // ADD immediate
        repeat (4) cycle(2'b00, 6'b001000, 1'b1);   // ADD register
        repeat (3) cycle(2'b10, 6'b000000, 1'b1);   // branch
        repeat (3) cycle(2'b11, 6'b111111, 1'b1);   // illegal

        // Store with three stalled MEMWR cycles on the handshake DUT.
        repeat (3) cycle(2'b01, 6'b000000, 1'b1);
        memw_cnt = int'(bus1.MemW);
        repeat (3) begin
            cycle(2'b01, 6'b000000, 1'b0);
            memw_cnt += int'(bus1.MemW);
        end
        cycle(2'b01, 6'b000000, 1'b1);
        chk("stall_memw_len", memw_cnt, 4);
        chk("stall_memw_exit", {31'd0, bus1.MemW}, 32'd0);

        // Realign both DUTs, then reset in the middle of a load's MEMRD.
        reset_pulse("realign");
        repeat (3) cycle(2'b01, 6'b000001, 1'b1);
        chk("pre_reset_memrd", {17'd0, obs0}, {17'd0, exp_ctl(L_MEMRD)});
        reset_pulse("reset_memrd");
        cycle(2'b01, 6'b000001, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            cycle(2'($urandom_range(0, 3)), 6'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
